// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the IF stage and its IF/ID pipeline register.
package fetch_stage_pkg;

  localparam int unsigned WordLen = 32;

  typedef enum logic [1:0] {
    FsBoot = 2'd0,
    FsRun  = 2'd1,
    FsHold = 2'd2
  } fs_state_e;

  localparam logic [WordLen-1:0] NopInst = '0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction memory, IF/ID outputs and perf counters.
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int unsigned WORD_LEN = WordLen
);
  logic                freeze;
  logic                branch_taken;
  logic [WORD_LEN-1:0] branch_addr;
  logic [WORD_LEN-1:0] inst_addr;
  logic [WORD_LEN-1:0] inst_in;
  logic [WORD_LEN-1:0] pc_ID;
  logic [WORD_LEN-1:0] inst_ID;
  logic                valid_ID;
  logic [15:0]         stall_cnt;
  logic [15:0]         flush_cnt;

  modport master (
    output freeze, branch_taken, branch_addr, inst_in,
    input  inst_addr, pc_ID, inst_ID, valid_ID, stall_cnt, flush_cnt
  );

  modport slave (
    input  freeze, branch_taken, branch_addr, inst_in,
    output inst_addr, pc_ID, inst_ID, valid_ID, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register pair (pc, inst) plus valid; loads on load_i, otherwise holds.
module fetch_stage_if_id_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] inst_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] inst_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] pc_q, inst_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, next-PC select, IF/ID register. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         WORD_LEN = WordLen,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter logic [WORD_LEN-1:0] PC_STEP  = WORD_LEN'(4)
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);
  fs_state_e           state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d, pc_plus;
  logic                fetch, bubble, hold, flush;

  assign pc_plus = pc_q + PC_STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fetch   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FsBoot: begin
        bubble  = 1'b1;
        state_d = FsRun;
      end
      FsRun, FsHold: begin
        // Freeze beats a simultaneous branch; the branch is re-presented after the stall.
        if (bus.freeze) begin
          hold    = 1'b1;
          state_d = FsHold;
        end else begin
          state_d = FsRun;
          if (bus.branch_taken) begin
            pc_d   = bus.branch_addr;
            bubble = 1'b1;
            flush  = 1'b1;
          end else begin
            pc_d  = pc_plus;
            fetch = 1'b1;
          end
        end
      end
      default: state_d = FsBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FsBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.inst_addr = pc_q;

  fetch_stage_if_id_reg #(
    .WIDTH(WORD_LEN)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (fetch | bubble),
    .pc_i   (fetch ? pc_plus : '0),
    .inst_i (fetch ? bus.inst_in : NopInst),
    .valid_i(fetch),
    .pc_o   (bus.pc_ID),
    .inst_o (bus.inst_ID),
    .valid_o(bus.valid_ID)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold) stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (flush) flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = hold ^ flush;
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] key = 32'hA5A5_0000;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory: each word is its address xor a key.
  always_comb bus.inst_in = bus.inst_addr ^ key;

  // Model: after reset one bubble cycle; then freeze holds, branch redirects with a bubble,
  // otherwise the word at PC is captured with PC+4.
  logic [31:0] m_pc, m_pc_id, m_inst_id;
  logic        m_valid, m_boot;
  int          m_stall, m_flush;
  logic [15:0] e_stall, e_flush;

  task automatic tick(input logic r, input logic f, input logic b, input logic [31:0] a);
    rst = r;
    bus.freeze = f;
    bus.branch_taken = b;
    bus.branch_addr = a;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_pc_id = 32'h0; m_inst_id = 32'h0; m_valid = 1'b0;
      m_boot = 1'b1; m_stall = 0; m_flush = 0;
    end else if (m_boot) begin
      m_pc_id = 32'h0; m_inst_id = 32'h0; m_valid = 1'b0; m_boot = 1'b0;
    end else if (f) begin
      if (m_stall < 65535) m_stall++;
    end else if (b) begin
      m_pc = a; m_pc_id = 32'h0; m_inst_id = 32'h0; m_valid = 1'b0;
      if (m_flush < 65535) m_flush++;
    end else begin
      m_inst_id = m_pc ^ key;
      m_pc = m_pc + 32'd4;
      m_pc_id = m_pc;
      m_valid = 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
    e_stall = 16'(m_stall);
    e_flush = 16'(m_flush);
`else
    e_stall = 16'h0;
    e_flush = 16'h0;
`endif
    #1;
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b1, 1'b1, 32'h1234);
    checks++;
    if ({bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset addr/pc/inst/valid got %h/%h/%h/%b want 0/0/0/0",
               bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID);
    end
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL reset_cnt got %h/%h want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    // Boot cycle ignores freeze and branch.
    tick(1'b0, 1'b1, 1'b1, 32'h300);
    checks++;
    if ({bus.inst_addr, bus.valid_ID} !== {32'h0, 1'b0}) begin
      fails++;
      $display("FAIL boot addr/valid got %h/%b want 0/0", bus.inst_addr, bus.valid_ID);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID} !==
          {32'(4 * (i + 1)), 32'(4 * (i + 1)), 32'(4 * i) ^ key, 1'b1}) begin
        fails++;
        $display("FAIL seq[%0d] addr/pc/inst/valid got %h/%h/%h/%b want %h/%h/%h/1", i,
                 bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID,
                 32'(4 * (i + 1)), 32'(4 * (i + 1)), 32'(4 * i) ^ key);
      end
    end
  endtask

  task automatic test_freeze;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if ({bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID} !==
          {32'h10, 32'h10, 32'hC ^ key, 1'b1}) begin
        fails++;
        $display("FAIL freeze[%0d] addr/pc/inst/valid got %h/%h/%h/%b want 10/10/%h/1", i,
                 bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID, 32'hC ^ key);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.inst_addr !== 32'h14) begin
      fails++;
      $display("FAIL freeze_release addr got %h want 14", bus.inst_addr);
    end
    checks++;
    if (bus.stall_cnt !== e_stall || e_stall !== 16'(m_stall > 0 ? e_stall : 0)) begin
      fails++;
      $display("FAIL stall_cnt got %0d want %0d", bus.stall_cnt, e_stall);
    end
  endtask

  task automatic test_branch;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8) tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h100);
    checks++;
    if ({bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID} !== {32'h100, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL branch addr/pc/inst/valid got %h/%h/%h/%b want 100/0/0/0",
               bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({bus.inst_ID, bus.pc_ID, bus.valid_ID} !== {32'h100 ^ key, 32'h104, 1'b1}) begin
      fails++;
      $display("FAIL branch_target inst/pc/valid got %h/%h/%b want %h/104/1",
               bus.inst_ID, bus.pc_ID, bus.valid_ID, 32'h100 ^ key);
    end
    checks++;
    if (bus.flush_cnt !== e_flush) begin
      fails++;
      $display("FAIL flush_cnt got %0d want %0d", bus.flush_cnt, e_flush);
    end
  endtask

  task automatic test_freeze_branch;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h200);
    checks++;
    if ({bus.inst_addr, bus.valid_ID} !== {32'h8, 1'b1}) begin
      fails++;
      $display("FAIL frz_br_hold addr/valid got %h/%b want 8/1", bus.inst_addr, bus.valid_ID);
    end
    tick(1'b0, 1'b0, 1'b1, 32'h200);
    checks++;
    if ({bus.inst_addr, bus.inst_ID, bus.valid_ID} !== {32'h200, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL frz_br_redirect addr/inst/valid got %h/%h/%b want 200/0/0",
               bus.inst_addr, bus.inst_ID, bus.valid_ID);
    end
  endtask

  task automatic test_reset_in_hold;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h40);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({bus.inst_addr, bus.valid_ID, bus.stall_cnt, bus.flush_cnt} !== {32'h0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL rst_hold addr/valid/stall/flush got %h/%b/%h/%h want 0/0/0/0",
               bus.inst_addr, bus.valid_ID, bus.stall_cnt, bus.flush_cnt);
    end
    tick(1'b0, 1'b1, 1'b1, 32'h80);
    checks++;
    if ({bus.inst_addr, bus.valid_ID} !== {32'h0, 1'b0}) begin
      fails++;
      $display("FAIL rst_boot addr/valid got %h/%b want 0/0", bus.inst_addr, bus.valid_ID);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({bus.inst_addr, bus.valid_ID} !== {32'h4, 1'b1}) begin
      fails++;
      $display("FAIL rst_run addr/valid got %h/%b want 4/1", bus.inst_addr, bus.valid_ID);
    end
  endtask

  task automatic test_wrap;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID} !==
        {32'h0, 32'h0, 32'hFFFF_FFFC ^ key, 1'b1}) begin
      fails++;
      $display("FAIL wrap addr/pc/inst/valid got %h/%h/%h/%b want 0/0/%h/1",
               bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID, 32'hFFFF_FFFC ^ key);
    end
  endtask

  task automatic test_random;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) key = $urandom;
      tick(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0, $urandom);
      checks++;
      if ({bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID, bus.stall_cnt, bus.flush_cnt} !==
          {m_pc, m_pc_id, m_inst_id, m_valid, e_stall, e_flush}) begin
        fails++;
        $display("FAIL rand[%0d] addr/pc/inst/valid/stall/flush got %h/%h/%h/%b/%h/%h want %h/%h/%h/%b/%h/%h",
                 i, bus.inst_addr, bus.pc_ID, bus.inst_ID, bus.valid_ID, bus.stall_cnt,
                 bus.flush_cnt, m_pc, m_pc_id, m_inst_id, m_valid, e_stall, e_flush);
      end
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_saturation;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (65540) tick(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL stall_sat got %h want ffff", bus.stall_cnt);
    end
  endtask
`endif

  initial begin
    m_boot = 1'b1;
    m_stall = 0;
    m_flush = 0;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch();
    test_freeze_branch();
    test_reset_in_hold();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    key = 32'hA5A5_0000;
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
